// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the pipelined MIPS control unit
// Purpose: opcode/func values, ALU op codes, control-bit indices, decode word
//          type and MDU FSM state encoding used by ctrl_decode and pipe_controller.
// Ports:   none (package)
package mips_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_MULT = 6'b011000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    // ALU operation codes
    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_SUB  = 5'b00110;
    localparam logic [4:0] ALU_NOR  = 5'b01100;
    localparam logic [4:0] ALU_SLL  = 5'b01101;
    localparam logic [4:0] ALU_SRL  = 5'b01110;
    localparam logic [4:0] ALU_SRA  = 5'b01111;
    localparam logic [4:0] ALU_MULT = 5'b10000;

    // muxctrl bit indices
    localparam int MUX_ALU_SRC    = 0;
    localparam int MUX_MEM_TO_REG = 1;
    localparam int MUX_REG_IN_LO  = 2;
    localparam int MUX_BUBBLE     = 4;

    // memctrl bit indices
    localparam int MEM_REG_WRITE = 0;
    localparam int MEM_WRITE     = 1;
    localparam int MEM_READ      = 2;

    typedef enum logic [1:0] {
        DST_NONE = 2'd0,
        DST_RD   = 2'd1,
        DST_RT   = 2'd2
    } dst_sel_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MDU_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [6:0] muxctrl;
        logic [2:0] memctrl;
        logic [4:0] aluctrl;
        dst_sel_e   dst_sel;
        logic       uses_rt;
        logic       is_branch;
        logic       is_mult;
        logic       illegal;
    } dec_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational op/func decoder for the ID stage
// Purpose: maps op/func to the control word plus hazard-relevant attributes.
// Ports:   op_i   [5:0]  opcode from IF/ID
//          func_i [5:0]  function field from IF/ID
//          dec_o         decoded word (mux/mem/alu, dst select, uses_rt,
//                        is_branch, is_mult, illegal)
module ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output dec_word_t  dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (op_i)
            OP_RTYPE: begin
                dec_o.memctrl[MEM_REG_WRITE] = 1'b1;
                dec_o.dst_sel                = DST_RD;
                dec_o.uses_rt                = 1'b1;
                case (func_i)
                    FN_ADD, FN_ADDU: dec_o.aluctrl = ALU_ADD;
                    FN_SUB, FN_SUBU: dec_o.aluctrl = ALU_SUB;
                    FN_AND:          dec_o.aluctrl = ALU_AND;
                    FN_OR:           dec_o.aluctrl = ALU_OR;
                    FN_NOR:          dec_o.aluctrl = ALU_NOR;
                    FN_SLL:          dec_o.aluctrl = ALU_SLL;
                    FN_SRL:          dec_o.aluctrl = ALU_SRL;
                    FN_SRA:          dec_o.aluctrl = ALU_SRA;
                    FN_MULT: begin
                        dec_o.aluctrl = ALU_MULT;
                        dec_o.is_mult = 1'b1;
                    end
                    default: begin
                        // unknown func: whole word collapses to a bubble
                        dec_o         = '0;
                        dec_o.illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dec_o.muxctrl[MUX_ALU_SRC]    = 1'b1;
                dec_o.muxctrl[MUX_MEM_TO_REG] = 1'b1;
                dec_o.memctrl[MEM_READ]       = 1'b1;
                dec_o.memctrl[MEM_REG_WRITE]  = 1'b1;
                dec_o.aluctrl                 = ALU_ADD;
                dec_o.dst_sel                 = DST_RT;
            end
            OP_SW: begin
                dec_o.muxctrl[MUX_ALU_SRC] = 1'b1;
                dec_o.memctrl[MEM_WRITE]   = 1'b1;
                dec_o.aluctrl              = ALU_ADD;
                dec_o.uses_rt              = 1'b1;
            end
            OP_BEQ: begin
                dec_o.aluctrl   = ALU_SUB;
                dec_o.uses_rt   = 1'b1;
                dec_o.is_branch = 1'b1;
            end
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - pipelined MIPS control unit with ID/EX register and hazards
// Purpose: decodes the IF/ID instruction, registers the control word into ID/EX,
//          and generates load-use stall, BEQ flush/pc_src and MULT occupancy stall.
// Ports:   clk, reset (async, active-high)
//          instr_valid, op, func, rs, rt, rd   IF/ID contents
//          zero                                ALU zero flag of the EX instruction
//          ex_muxctrl, ex_memctrl, ex_aluctrl, ex_dst   registered ID/EX controls
//          stall, flush, pc_src                combinational pipeline controls
//          illegal                             registered unknown-instruction flag
module pipe_controller
    import mips_ctrl_pkg::*;
#(
    parameter int MUXW    = 7,
    parameter int MEMW    = 3,
    parameter int ALUW    = 5,
    parameter int RW      = 5,
    parameter int MDU_LAT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [5:0]      op,
    input  logic [5:0]      func,
    input  logic [RW-1:0]   rs,
    input  logic [RW-1:0]   rt,
    input  logic [RW-1:0]   rd,
    input  logic            zero,
    output logic [MUXW-1:0] ex_muxctrl,
    output logic [MEMW-1:0] ex_memctrl,
    output logic [ALUW-1:0] ex_aluctrl,
    output logic [RW-1:0]   ex_dst,
    output logic            stall,
    output logic            flush,
    output logic            pc_src,
    output logic            illegal
);

    localparam int CNTW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    dec_word_t dec;

    logic [MUXW-1:0] ex_muxctrl_q, ex_muxctrl_d;
    logic [MEMW-1:0] ex_memctrl_q, ex_memctrl_d;
    logic [ALUW-1:0] ex_aluctrl_q, ex_aluctrl_d;
    logic [RW-1:0]   ex_dst_q,     ex_dst_d;
    logic            ex_branch_q,  ex_branch_d;
    logic            illegal_q,    illegal_d;
    mdu_state_e      state_q,      state_d;
    logic [CNTW-1:0] cnt_q,        cnt_d;

    logic            mdu_hold;
    logic            load_use;
    logic            branch_taken;
    logic [RW-1:0]   dec_dst;

    ctrl_decode u_decode (
        .op_i   (op),
        .func_i (func),
        .dec_o  (dec)
    );

    // MULT still occupies EX while the counter is non-zero; at zero the
    // state is left one cycle later without stalling.
    assign mdu_hold     = (state_q == ST_MDU_BUSY) && (cnt_q != '0);
    assign branch_taken = ex_branch_q & zero;

    assign load_use = instr_valid && !mdu_hold
                   && ex_memctrl_q[MEM_READ] && (ex_dst_q != '0)
                   && ((ex_dst_q == rs) || (dec.uses_rt && (ex_dst_q == rt)));

    assign stall  = !branch_taken && (mdu_hold || load_use);
    assign flush  = branch_taken;
    assign pc_src = branch_taken;

    always_comb begin
        dec_dst = '0;
        case (dec.dst_sel)
            DST_RD:  dec_dst = rd;
            DST_RT:  dec_dst = rt;
            default: dec_dst = '0;
        endcase
    end

    always_comb begin
        ex_muxctrl_d = ex_muxctrl_q;
        ex_memctrl_d = ex_memctrl_q;
        ex_aluctrl_d = ex_aluctrl_q;
        ex_dst_d     = ex_dst_q;
        ex_branch_d  = ex_branch_q;
        illegal_d    = illegal_q;
        state_d      = state_q;
        cnt_d        = cnt_q;

        if (mdu_hold) begin
            cnt_d = cnt_q - CNTW'(1);
        end else begin
            state_d      = ST_IDLE;
            cnt_d        = '0;
            ex_muxctrl_d = '0;
            ex_memctrl_d = '0;
            ex_aluctrl_d = '0;
            ex_dst_d     = '0;
            ex_branch_d  = 1'b0;
            illegal_d    = 1'b0;
            // flush beats everything; a load-use stall inserts a bubble and
            // lets the instruction be re-decoded next cycle
            if (!branch_taken && instr_valid && !load_use) begin
                if (dec.illegal) begin
                    illegal_d = 1'b1;
                end else begin
                    ex_muxctrl_d = MUXW'(dec.muxctrl);
                    ex_memctrl_d = MEMW'(dec.memctrl);
                    ex_aluctrl_d = ALUW'(dec.aluctrl);
                    ex_dst_d     = dec_dst;
                    ex_branch_d  = dec.is_branch;
                    if (dec.is_mult) begin
                        state_d = ST_MDU_BUSY;
                        cnt_d   = CNTW'(MDU_LAT - 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_muxctrl_q <= '0;
            ex_memctrl_q <= '0;
            ex_aluctrl_q <= '0;
            ex_dst_q     <= '0;
            ex_branch_q  <= 1'b0;
            illegal_q    <= 1'b0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
        end else begin
            ex_muxctrl_q <= ex_muxctrl_d;
            ex_memctrl_q <= ex_memctrl_d;
            ex_aluctrl_q <= ex_aluctrl_d;
            ex_dst_q     <= ex_dst_d;
            ex_branch_q  <= ex_branch_d;
            illegal_q    <= illegal_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
        end
    end

    assign ex_muxctrl = ex_muxctrl_q;
    assign ex_memctrl = ex_memctrl_q;
    assign ex_aluctrl = ex_aluctrl_q;
    assign ex_dst     = ex_dst_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_pipe_controller.sv
// tb/tb_pipe_controller.sv - directed self-checking bench for pipe_controller
module tb_pipe_controller;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_MULT = 6'b011000;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [5:0] op, func;
    logic [4:0] rs, rt, rd;
    logic       zero;
    logic [6:0] ex_muxctrl;
    logic [2:0] ex_memctrl;
    logic [4:0] ex_aluctrl;
    logic [4:0] ex_dst;
    logic       stall, flush, pc_src, illegal;

    int n_checks = 0;
    int n_errors = 0;

    pipe_controller #(.MUXW(7), .MEMW(3), .ALUW(5), .RW(5), .MDU_LAT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .op          (op),
        .func        (func),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .zero        (zero),
        .ex_muxctrl  (ex_muxctrl),
        .ex_memctrl  (ex_memctrl),
        .ex_aluctrl  (ex_aluctrl),
        .ex_dst      (ex_dst),
        .stall       (stall),
        .flush       (flush),
        .pc_src      (pc_src),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] o, input logic [5:0] f,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        instr_valid = v;
        op          = o;
        func        = f;
        rs          = s;
        rt          = t;
        rd          = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        zero  = 1'b0;
        drive(1'b0, OP_R, F_ADD, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        check("rst_mux", ex_muxctrl, 0);
        check("rst_mem", ex_memctrl, 0);
        check("rst_alu", ex_aluctrl, 0);
        check("rst_dst", ex_dst, 0);
        check("rst_ctl", {stall, flush, pc_src, illegal}, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1) ADD rd=3, then asynchronous reset mid-cycle
        drive(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd3);
        tick();
        check("add_mem", ex_memctrl, 3'b001);
        check("add_alu", ex_aluctrl, 5'b00010);
        check("add_dst", ex_dst, 3);
        check("add_mux", ex_muxctrl, 0);
        #2 reset = 1'b1;
        #1;
        check("async_mem", ex_memctrl, 0);
        check("async_dst", ex_dst, 0);
        @(negedge clk);
        reset = 1'b0;

        // 2) LW rt=5 then ADD rs=5: one-cycle load-use stall
        drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd5, 5'd0);
        tick();
        check("lw_mem", ex_memctrl, 3'b101);
        check("lw_mux", ex_muxctrl, 7'b0000011);
        check("lw_dst", ex_dst, 5);
        drive(1'b1, OP_R, F_ADD, 5'd5, 5'd2, 5'd7);
        #1;
        check("lu_stall", stall, 1);
        tick();
        check("lu_bub_mem", ex_memctrl, 0);
        check("lu_bub_dst", ex_dst, 0);
        check("lu_stall_drop", stall, 0);
        tick();
        check("lu_add_dst", ex_dst, 7);
        check("lu_add_mem", ex_memctrl, 3'b001);

        // 3) LW rt=0 never interlocks; LW rt=5 then SW rt=5 does
        drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd0, 5'd0);
        tick();
        drive(1'b1, OP_R, F_ADD, 5'd0, 5'd0, 5'd4);
        #1;
        check("r0_nostall", stall, 0);
        tick();
        check("r0_dst", ex_dst, 4);
        drive(1'b1, OP_LW, 6'd0, 5'd1, 5'd5, 5'd0);
        tick();
        drive(1'b1, OP_SW, 6'd0, 5'd1, 5'd5, 5'd0);
        #1;
        check("sw_stall", stall, 1);
        tick();
        check("sw_bub_mem", ex_memctrl, 0);
        tick();
        check("sw_mem", ex_memctrl, 3'b010);
        check("sw_mux", ex_muxctrl, 7'b0000001);
        check("sw_dst", ex_dst, 0);

        // 4) BEQ taken flushes; not taken does not
        drive(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        check("beq_alu", ex_aluctrl, 5'b00110);
        check("beq_mem", ex_memctrl, 0);
        zero = 1'b1;
        drive(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd9);
        #1;
        check("beq_pcsrc", pc_src, 1);
        check("beq_flush", flush, 1);
        check("beq_stall", stall, 0);
        tick();
        check("flush_bub_mem", ex_memctrl, 0);
        check("flush_bub_dst", ex_dst, 0);
        check("flush_pcsrc_drop", pc_src, 0);
        zero = 1'b0;
        drive(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd9);
        #1;
        check("nt_flush", flush, 0);
        check("nt_pcsrc", pc_src, 0);
        tick();
        check("nt_dst", ex_dst, 9);

        // 5) MULT holds EX for MDU_LAT cycles: three stall cycles
        drive(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 5'd0);
        tick();
        check("mult_alu", ex_aluctrl, 5'b10000);
        drive(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd10);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mult_stall%0d", i), stall, 1);
            check($sformatf("mult_hold%0d", i), ex_aluctrl, 5'b10000);
            tick();
        end
        check("mult_release", stall, 0);
        check("mult_last_alu", ex_aluctrl, 5'b10000);
        tick();
        check("mult_next_dst", ex_dst, 10);
        check("mult_next_alu", ex_aluctrl, 5'b00010);

        // 5b) reset in the second MULT stall cycle
        drive(1'b1, OP_R, F_MULT, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd10);
        tick();
        check("mrst_pre_stall", stall, 1);
        #1 reset = 1'b1;
        #1;
        check("mrst_stall", stall, 0);
        check("mrst_alu", ex_aluctrl, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("mrst_idle_stall", stall, 0);
        check("mrst_idle_dst", ex_dst, 10);

        // 6) illegal opcode, then illegal under a taken branch
        drive(1'b1, OP_BAD, 6'd0, 5'd1, 5'd2, 5'd3);
        tick();
        check("ill_flag", illegal, 1);
        check("ill_bub", {ex_muxctrl, ex_memctrl, ex_aluctrl, ex_dst}, 0);
        drive(1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd11);
        tick();
        check("ill_clear", illegal, 0);
        check("ill_next_dst", ex_dst, 11);
        drive(1'b1, OP_BEQ, 6'd0, 5'd1, 5'd2, 5'd0);
        tick();
        zero = 1'b1;
        drive(1'b1, OP_BAD, 6'd0, 5'd1, 5'd2, 5'd3);
        #1;
        check("ill_br_flush", flush, 1);
        tick();
        check("ill_br_illegal", illegal, 0);
        check("ill_br_mem", ex_memctrl, 0);
        zero = 1'b0;

        // instr_valid=0 loads a bubble
        drive(1'b0, OP_R, F_ADD, 5'd1, 5'd2, 5'd12);
        tick();
        check("inv_mem", ex_memctrl, 0);
        check("inv_dst", ex_dst, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
